// File: rtl/controller_if.sv
// Handshake/bus bundle between a BIST master and the array test sequencer.
// Ports: en (start request, from the master); act/rd/wr strobes and the write-side
//        and read-side row/column address buses (from the sequencer).
interface controller_if #(
  parameter int ADDR_W = 8
);
  logic              en;
  logic              act;
  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr_row_w;
  logic [ADDR_W-1:0] addr_col_w;
  logic [ADDR_W-1:0] addr_row_r;
  logic [ADDR_W-1:0] addr_col_r;

  // Test master side: requests a sweep and observes the command stream.
  modport master (
    output en,
    input  act, rd, wr, addr_row_w, addr_col_w, addr_row_r, addr_col_r
  );

  // Sequencer side: consumes the request and drives the command stream.
  modport slave (
    input  en,
    output act, rd, wr, addr_row_w, addr_col_w, addr_row_r, addr_col_r
  );
endinterface

// File: rtl/controller.sv
// Memory-array test sequencer: on en (sampled only in IDLE) writes every (row,col) cell,
// then reads every cell back, issuing act / wr / rd strobes with RCD and precharge gaps.
// Ports: clk, rst (async active-high), bus (controller_if.slave: en in; act/rd/wr and
//        write-side/read-side row+column addresses out, all registered).
module controller #(
  parameter int ADDR_W  = 8,
  parameter int ROW_MAX = 255,
  parameter int COL_MAX = 255,
  parameter int T_RCD   = 2,
  parameter int T_RP    = 2
) (
  input  logic        clk,
  input  logic        rst,
  controller_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, ACT_W, RCD_W, WRITE, PRE_W, ACT_R, RCD_R, READ, PRE_R, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROW_MAX);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(COL_MAX);
  // Wait counters are loaded with (cycles - 1) and count down to zero.
  // RCD_INIT is only used when T_RCD > 1.
  localparam logic [15:0]       RCD_INIT = 16'(T_RCD - 2);
  localparam logic [15:0]       RP_INIT  = 16'(T_RP - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] row_q;
  logic [ADDR_W-1:0] col_q;
  logic [15:0]       cnt_q;
  logic              act_q;
  logic              rd_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_row_w_q;
  logic [ADDR_W-1:0] addr_col_w_q;
  logic [ADDR_W-1:0] addr_row_r_q;
  logic [ADDR_W-1:0] addr_col_r_q;

  // Outputs are computed together with the next state so every strobe and
  // address is a flop that lines up with the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      cnt_q        <= '0;
      act_q        <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_row_w_q <= '0;
      addr_col_w_q <= '0;
      addr_row_r_q <= '0;
      addr_col_r_q <= '0;
    end else begin
      // Strobes and column buses are single-cycle unless re-asserted below;
      // row buses hold for the whole phase.
      act_q        <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_col_w_q <= '0;
      addr_col_r_q <= '0;

      case (state_q)
        IDLE: begin
          if (bus.en) begin
            state_q      <= ACT_W;
            row_q        <= '0;
            act_q        <= 1'b1;
            addr_row_w_q <= '0;
          end
        end

        ACT_W: begin
          col_q <= '0;
          if (T_RCD > 1) begin
            state_q <= RCD_W;
            cnt_q   <= RCD_INIT;
          end else begin
            state_q <= WRITE;
            wr_q    <= 1'b1;
          end
        end

        RCD_W: begin
          if (cnt_q == '0) begin
            state_q <= WRITE;
            wr_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end

        WRITE: begin
          if (col_q == COL_LAST) begin
            state_q <= PRE_W;
            cnt_q   <= RP_INIT;
          end else begin
            col_q        <= col_q + 1'b1;
            wr_q         <= 1'b1;
            addr_col_w_q <= col_q + 1'b1;
          end
        end

        PRE_W: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 16'd1;
          end else if (row_q == ROW_LAST) begin
            // Write sweep complete: drop the write row bus, start reads at row 0.
            state_q      <= ACT_R;
            row_q        <= '0;
            act_q        <= 1'b1;
            addr_row_w_q <= '0;
            addr_row_r_q <= '0;
          end else begin
            state_q      <= ACT_W;
            row_q        <= row_q + 1'b1;
            act_q        <= 1'b1;
            addr_row_w_q <= row_q + 1'b1;
          end
        end

        ACT_R: begin
          col_q <= '0;
          if (T_RCD > 1) begin
            state_q <= RCD_R;
            cnt_q   <= RCD_INIT;
          end else begin
            state_q <= READ;
            rd_q    <= 1'b1;
          end
        end

        RCD_R: begin
          if (cnt_q == '0) begin
            state_q <= READ;
            rd_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end

        READ: begin
          if (col_q == COL_LAST) begin
            state_q <= PRE_R;
            cnt_q   <= RP_INIT;
          end else begin
            col_q        <= col_q + 1'b1;
            rd_q         <= 1'b1;
            addr_col_r_q <= col_q + 1'b1;
          end
        end

        PRE_R: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 16'd1;
          end else if (row_q == ROW_LAST) begin
            state_q      <= DONE;
            row_q        <= '0;
            addr_row_r_q <= '0;
          end else begin
            state_q      <= ACT_R;
            row_q        <= row_q + 1'b1;
            act_q        <= 1'b1;
            addr_row_r_q <= row_q + 1'b1;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.act        = act_q;
  assign bus.rd         = rd_q;
  assign bus.wr         = wr_q;
  assign bus.addr_row_w = addr_row_w_q;
  assign bus.addr_col_w = addr_col_w_q;
  assign bus.addr_row_r = addr_row_r_q;
  assign bus.addr_col_r = addr_col_r_q;

endmodule

// File: tb/tb_controller.sv
// Directed bench for the array test sequencer, small geometry (2 rows x 4 cols, RCD=2, RP=2).
// Ports: none (top-level bench); drives clk/rst and the interface en, checks every output each cycle.
module tb_controller;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  controller_if #(.ADDR_W(8)) bus ();

  controller #(
    .ADDR_W (8),
    .ROW_MAX(1),
    .COL_MAX(3),
    .T_RCD  (2),
    .T_RP   (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {act,rd,wr,row_w,col_w,row_r,col_r} for cycle c of a sequence whose
  // en was sampled at the edge ending cycle 0. Per-row period is 8 cycles:
  // offset 0 act, 1 RCD, 2..5 column strobes, 6..7 precharge. Rows 0,1 write
  // (cycles 1..16), rows 0,1 read (17..32), DONE at 33, idle otherwise.
  function automatic logic [34:0] exp_vec(input int c);
    logic       a, r, w;
    logic [7:0] rw, cw, rrow, cr;
    int         p, ph, row, o;
    a = 1'b0; r = 1'b0; w = 1'b0;
    rw = 8'd0; cw = 8'd0; rrow = 8'd0; cr = 8'd0;
    if (c >= 1 && c <= 32) begin
      p   = c - 1;
      ph  = p / 16;
      row = (p % 16) / 8;
      o   = p % 8;
      a   = (o == 0);
      if (ph == 0) begin
        rw = 8'(row);
        if (o >= 2 && o <= 5) begin
          w  = 1'b1;
          cw = 8'(o - 2);
        end
      end else begin
        rrow = 8'(row);
        if (o >= 2 && o <= 5) begin
          r  = 1'b1;
          cr = 8'(o - 2);
        end
      end
    end
    return {a, r, w, rw, cw, rrow, cr};
  endfunction

  function automatic logic [34:0] obs_vec();
    return {bus.act, bus.rd, bus.wr, bus.addr_row_w, bus.addr_col_w,
            bus.addr_row_r, bus.addr_col_r};
  endfunction

  task automatic check_vec(input string tag, input int c, input logic [34:0] expv);
    logic [34:0] got;
    got = obs_vec();
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s cyc=%0d got act/rd/wr=%b%b%b rw=%0d cw=%0d rr=%0d cr=%0d exp act/rd/wr=%b%b%b rw=%0d cw=%0d rr=%0d cr=%0d",
             tag, c, got[34], got[33], got[32], got[31:24], got[23:16], got[15:8], got[7:0],
             expv[34], expv[33], expv[32], expv[31:24], expv[23:16], expv[15:8], expv[7:0]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    bus.en   = 1'b0;

    // Reset asserted between edges clears outputs without a clock.
    #1 rst = 1'b1;
    #1 check_vec("reset_async", 0, 35'd0);
    @(negedge clk);
    check_vec("reset_held", 0, 35'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_vec("idle_en0", i, 35'd0);
    end

    // Basic single-pulse run, plus two idle cycles after DONE.
    bus.en = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      check_vec("basic", c, exp_vec(c));
      if (c == 1) bus.en = 1'b0;
    end

    // en pulses during WRITE (cycle 4) and DONE (cycle 33) are ignored.
    @(negedge clk);
    bus.en = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      check_vec("en_ignored", c, exp_vec(c));
      bus.en = (c == 4 || c == 33);
    end

    // Reset mid read phase (cycle 20, rd active) clears outputs immediately.
    @(negedge clk);
    bus.en = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      check_vec("pre_rst", c, exp_vec(c));
      if (c == 1) bus.en = 1'b0;
    end
    #2 rst = 1'b1;
    #1 check_vec("rst_mid_read", 20, 35'd0);
    @(negedge clk);
    check_vec("rst_mid_held", 21, 35'd0);
    rst = 1'b0;
    @(negedge clk);
    check_vec("post_rst_idle", 22, 35'd0);

    // Restart after reset begins again at row 0 of the write phase.
    bus.en = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      check_vec("restart", c, exp_vec(c));
      if (c == 1) bus.en = 1'b0;
    end

    // en held high: second sequence starts from the IDLE cycle after DONE.
    @(negedge clk);
    bus.en = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      check_vec("back_to_back", c, exp_vec(c > 34 ? c - 34 : c));
      if (c == 67) bus.en = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
